// File: rtl/hamming74_serial_decoder.sv
// Hamming(7,4) serial receive stage.
// Deserializes 7-bit codewords that arrive LSB first over a valid/ready bit
// interface. It computes the syndrome, corrects a single-bit error and presents
// the 4-bit data word in a one-deep valid/ready output register. It also keeps
// saturating counts of completed frames and of corrected frames.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   bit_in          serial codeword bit, code[0] first
//   bit_valid       bit_in valid this cycle
//   frame_start     marks an accepted bit as code[0] of a new frame
//   in_ready        decoder can accept a bit this cycle
//   data_out        corrected data {d3,d2,d1,d0}
//   syndrome_out    raw syndrome of the delivered codeword
//   err_corrected   syndrome_out != 0
//   out_valid       output register holds an undelivered word
//   out_ready       consumer accepts the word
//   frame_count     frames completed (saturating)
//   corr_count      frames with nonzero syndrome (saturating)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a frame_start bit; other accepted bits dropped
// COLLECT | shifting in code[1..6]; idx_q is the next bit position

module hamming74_serial_decoder #(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               bit_in,
   input  logic               bit_valid,
   input  logic               frame_start,
   output logic               in_ready,
   output logic [3:0]         data_out,
   output logic [2:0]         syndrome_out,
   output logic               err_corrected,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [COUNT_W-1:0] frame_count,
   output logic [COUNT_W-1:0] corr_count
);

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t               state_q, state_d;
   logic [2:0]           idx_q, idx_d;
   logic [5:0]           shreg_q, shreg_d;
   logic [3:0]           data_q, data_d;
   logic [2:0]           synd_q, synd_d;
   logic                 err_q, err_d;
   logic                 ov_q, ov_d;
   logic [COUNT_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [COUNT_W-1:0]   corr_cnt_q, corr_cnt_d;

   logic                 accept;
   logic                 complete;
   logic [6:0]           code;
   logic [2:0]           syn;
   logic [6:0]           flip;
   logic [6:0]           fixed;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      synd_d      = synd_q;
      err_d       = err_q;
      ov_d        = ov_q && !out_ready;
      frame_cnt_d = frame_cnt_q;
      corr_cnt_d  = corr_cnt_q;
      complete    = 1'b0;

      // Stall only the final bit, and only while the output register is full.
      // The earlier bits can always be shifted in.
      in_ready = !(state_q == COLLECT && idx_q == 3'd6 && ov_q && !out_ready);
      accept   = bit_valid && in_ready;

      // The 7th bit is still on bit_in at the completion edge.
      code   = {bit_in, shreg_q};
      syn[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
      syn[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
      syn[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
      flip   = 7'd0;
      if (syn != 3'd0) begin
         flip = 7'd1 << (syn - 3'd1);
      end
      fixed = code ^ flip;

      if (accept) begin
         if (frame_start) begin
            shreg_d = {5'd0, bit_in};
            idx_d   = 3'd1;
            state_d = COLLECT;
         end else if (state_q == COLLECT) begin
            if (idx_q == 3'd6) begin
               complete = 1'b1;
               idx_d    = 3'd0;
               state_d  = IDLE;
            end else begin
               shreg_d[idx_q] = bit_in;
               idx_d          = idx_q + 3'd1;
            end
         end
      end

      // A load on the same edge as a handshake wins over the clear.
      if (complete) begin
         data_d = {fixed[6], fixed[5], fixed[4], fixed[2]};
         synd_d = syn;
         err_d  = (syn != 3'd0);
         ov_d   = 1'b1;
         if (frame_cnt_q != {COUNT_W{1'b1}}) begin
            frame_cnt_d = frame_cnt_q + COUNT_W'(1);
         end
         if (syn != 3'd0 && corr_cnt_q != {COUNT_W{1'b1}}) begin
            corr_cnt_d = corr_cnt_q + COUNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= 3'd0;
         shreg_q     <= 6'd0;
         data_q      <= 4'd0;
         synd_q      <= 3'd0;
         err_q       <= 1'b0;
         ov_q        <= 1'b0;
         frame_cnt_q <= '0;
         corr_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         synd_q      <= synd_d;
         err_q       <= err_d;
         ov_q        <= ov_d;
         frame_cnt_q <= frame_cnt_d;
         corr_cnt_q  <= corr_cnt_d;
      end
   end

   assign data_out      = data_q;
   assign syndrome_out  = synd_q;
   assign err_corrected = err_q;
   assign out_valid     = ov_q;
   assign frame_count   = frame_cnt_q;
   assign corr_count    = corr_cnt_q;

endmodule

// File: tb/tb_hamming74_serial_decoder.sv
module tb_hamming74_serial_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       frame_start = 1'b0;
   logic       out_ready = 1'b1;
   logic       in_ready, err_corrected, out_valid;
   logic [3:0] data_out;
   logic [2:0] syndrome_out;
   logic [7:0] frame_count, corr_count;

   logic       s_in_ready, s_err, s_ov;
   logic [3:0] s_data;
   logic [2:0] s_synd;
   logic [1:0] s_frame_count, s_corr_count;

   int n_cmp = 0;
   int n_err = 0;

   // expected words {err, syndrome, data}
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   hamming74_serial_decoder #(.COUNT_W(8)) dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
      .frame_start(frame_start), .in_ready(in_ready), .data_out(data_out),
      .syndrome_out(syndrome_out), .err_corrected(err_corrected),
      .out_valid(out_valid), .out_ready(out_ready),
      .frame_count(frame_count), .corr_count(corr_count)
   );

   hamming74_serial_decoder #(.COUNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
      .frame_start(frame_start), .in_ready(s_in_ready), .data_out(s_data),
      .syndrome_out(s_synd), .err_corrected(s_err),
      .out_valid(s_ov), .out_ready(out_ready),
      .frame_count(s_frame_count), .corr_count(s_corr_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a word is delivered on a rising edge with out_valid && out_ready.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_word: got data=%0h synd=%0d err=%0b with nothing expected",
                     data_out, syndrome_out, err_corrected);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if ({err_corrected, syndrome_out, data_out} !== e) begin
               n_err++;
               $display("FAIL word: got data=%0h synd=%0d err=%0b expected data=%0h synd=%0d err=%0b",
                        data_out, syndrome_out, err_corrected, e[3:0], e[6:4], e[7]);
            end
         end
      end
   end

   function automatic logic [6:0] encode(input logic [3:0] d);
      logic [6:0] c;
      c[2] = d[0];
      c[4] = d[1];
      c[5] = d[2];
      c[6] = d[3];
      c[0] = d[0] ^ d[1] ^ d[3];
      c[1] = d[0] ^ d[2] ^ d[3];
      c[3] = d[1] ^ d[2] ^ d[3];
      return c;
   endfunction

   // Called and returns at posedge+1; bit_valid is left high.
   task automatic send_bit(input logic b, input logic fs);
      logic rdy;
      int   n;
      bit_in = b;
      frame_start = fs;
      bit_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 200);
      if (!rdy) begin
         n_cmp++;
         n_err++;
         $display("FAIL bit_accept_timeout: in_ready=%0b after %0d cycles, required 1", rdy, n);
      end
   endtask

   task automatic send_frame(input logic [6:0] c);
      for (int i = 0; i < 7; i++) send_bit(c[i], i == 0);
   endtask

   task automatic idle(input int n);
      bit_valid = 1'b0;
      frame_start = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      bit_valid = 1'b0;
      frame_start = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_in_ready"}, in_ready, 1'b1);
      chk({tag, "_data_out"}, data_out, 4'h0);
      chk({tag, "_frame_count"}, frame_count, 8'd0);
      chk({tag, "_corr_count"}, corr_count, 8'd0);
   endtask

   initial begin
      logic [6:0] c;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      chk_reset_state("reset");
      chk("reset_syndrome", {err_corrected, syndrome_out}, 4'h0);

      // Clean frame: 4'hB encodes to 7'h55
      out_ready = 1'b1;
      exp_q.push_back({1'b0, 3'd0, 4'hB});
      send_frame(7'h55);
      bit_valid = 1'b0;
      chk("clean_out_valid_next_cycle", out_valid, 1'b1);
      chk("clean_frame_count", frame_count, 8'd1);
      chk("clean_corr_count", corr_count, 8'd0);
      idle(1);
      chk("clean_out_valid_pulse", out_valid, 1'b0);

      // Single error at bit 4
      exp_q.push_back({1'b1, 3'd5, 4'hB});
      send_frame(7'h45);
      idle(2);
      chk("single_frame_count", frame_count, 8'd2);
      chk("single_corr_count", corr_count, 8'd1);

      // Every data word, every error position
      do_reset();
      for (int d = 0; d < 16; d++) begin
         for (int p = 0; p < 7; p++) begin
            c = encode(4'(d));
            c[p] = ~c[p];
            exp_q.push_back({1'b1, 3'(p + 1), 4'(d)});
            send_frame(c);
         end
      end
      idle(3);
      chk("sweep_frame_count", frame_count, 8'd112);
      chk("sweep_corr_count", corr_count, 8'd112);
      chk("sweep_queue_drained", exp_q.size(), 0);

      // Backpressure: two back-to-back frames with the consumer stalled
      do_reset();
      out_ready = 1'b0;
      exp_q.push_back({1'b0, 3'd0, 4'h0});
      exp_q.push_back({1'b0, 3'd0, 4'hF});
      fork
         begin
            send_frame(7'h00);
            send_frame(7'h7F);
            bit_valid = 1'b0;
         end
         begin
            repeat (20) begin
               @(posedge clk);
               #1;
            end
            chk("bp_in_ready_low", in_ready, 1'b0);
            chk("bp_held_valid", out_valid, 1'b1);
            chk("bp_held_data", data_out, 4'h0);
            chk("bp_frame_count_mid", frame_count, 8'd1);
            out_ready = 1'b1;
         end
      join
      idle(3);
      chk("bp_frame_count", frame_count, 8'd2);
      chk("bp_queue_drained", exp_q.size(), 0);

      // Resync, and bits without frame_start in IDLE
      do_reset();
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
      idle(3);
      chk("idle_discard_valid", out_valid, 1'b0);
      chk("idle_discard_count", frame_count, 8'd0);
      c = 7'h55;
      for (int i = 0; i < 3; i++) send_bit(c[i], i == 0);
      exp_q.push_back({1'b0, 3'd0, 4'hF});
      send_frame(7'h7F);
      idle(3);
      chk("resync_frame_count", frame_count, 8'd1);
      chk("resync_corr_count", corr_count, 8'd0);
      chk("resync_queue_drained", exp_q.size(), 0);

      // Reset mid-frame
      do_reset();
      c = 7'h55;
      for (int i = 0; i < 4; i++) send_bit(c[i], i == 0);
      do_reset();
      chk_reset_state("rst_midframe");
      // Reset with a pending word
      out_ready = 1'b0;
      send_frame(7'h7F);
      bit_valid = 1'b0;
      chk("rst_pending_valid_before", out_valid, 1'b1);
      do_reset();
      chk_reset_state("rst_pending");
      out_ready = 1'b1;
      exp_q.push_back({1'b0, 3'd0, 4'hB});
      send_frame(7'h55);
      bit_valid = 1'b0;
      chk("rst_after_data", data_out, 4'hB);
      idle(2);
      chk("rst_after_frame_count", frame_count, 8'd1);

      // Saturation on the narrow-counter instance
      do_reset();
      chk("sat_reset_frame", s_frame_count, 2'd0);
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back({1'b1, 3'd5, 4'hB});
         send_frame(7'h45);
      end
      idle(3);
      chk("sat_frame_count", s_frame_count, 2'd3);
      chk("sat_corr_count", s_corr_count, 2'd3);
      chk("sat_wide_frame_count", frame_count, 8'd5);
      chk("sat_queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hamming74_serial_decoder.md
Name: hamming74_serial_decoder

Overview:
Downstream receive stage for the codes_ex_top Hamming(7,4) encoder. Accepts 7-bit codewords bit-serially through a valid/ready handshake and deserializes them. Computes the syndrome, corrects any single-bit error, and presents the 4-bit data word on a one-deep valid/ready output register. Keeps saturating statistics counters for frames received and frames corrected.

Parameters:
COUNT_W, 8, width of frame_count and corr_count (saturating)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
bit_in  in  1  serial codeword bit, LSB (code[0]) first
bit_valid  in  1  bit_in valid this cycle
frame_start  in  1  qualifies an accepted bit as code[0] of a new frame
in_ready  out  1  decoder can accept a bit this cycle
data_out  out  4  corrected data {d3,d2,d1,d0}
syndrome_out  out  3  raw syndrome of the delivered codeword
err_corrected  out  1  syndrome_out != 0 for the delivered word
out_valid  out  1  output register holds an undelivered word
out_ready  in  1  consumer accepts the word
frame_count  out  COUNT_W  frames completed, saturating
corr_count  out  COUNT_W  frames with nonzero syndrome, saturating

Behaviour:
- Codeword map: code[0]=p1, code[1]=p2, code[2]=d0, code[3]=p4, code[4]=d1, code[5]=d2, code[6]=d3.
- Parity: p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3.
- Syndrome s={s4,s2,s1}:
  - s1=c0^c2^c4^c6, s2=c1^c2^c5^c6, s4=c3^c4^c5^c6.
  - Nonzero s is the 1-based error position; invert code[s-1] before extracting data.
  - Double errors are miscorrected silently. This is by design.
- Accept: a bit is accepted on a rising edge when bit_valid && in_ready.
- FSM states:
  - IDLE: accepted bits with frame_start=0 are discarded. An accepted bit with frame_start=1 stores code[0], sets idx=1, and moves to COLLECT.
  - COLLECT: each accepted bit stores code[idx] and increments idx.
    - An accepted bit with frame_start=1 resyncs: the partial frame is dropped, the bit becomes code[0], and idx=1.
    - On the accepted bit at idx=6, the codeword is complete. Go to IDLE.
- Completion edge:
  - Syndrome and correction are computed combinationally from {bit_in, shreg[5:0]}.
  - data_out, syndrome_out, and err_corrected are loaded, and out_valid=1, on the same edge.
  - Latency: out_valid is high in the cycle after the 7th bit is accepted.
- Output register:
  - Holds its value while out_valid && !out_ready.
  - Clears out_valid on an out_valid && out_ready edge unless reloaded on that same edge (load wins).
- in_ready:
  - Equals 1 except when state=COLLECT, idx=6, out_valid=1 and out_ready=0. The 7th bit then stalls, and no data is lost.
  - A combinational path from out_ready to in_ready is permitted.
- Counters:
  - frame_count increments on every completion edge.
  - corr_count increments on a completion edge with nonzero syndrome.
  - Both hold at 2^COUNT_W-1.
  - Resynced (partial) frames increment neither counter.
- Reset (any cycle, including mid-frame or with out_valid high):
  - state=IDLE, idx=0, shreg=0, in_ready=1.
  - data_out=0, syndrome_out=0, err_corrected=0, out_valid=0.
  - frame_count=0, corr_count=0.
  - Any partial frame and any pending output are discarded.

Test Plan:
- Clean frame: send data 4'b1011 as code 7'h55 LSB first, frame_start on bit 0, out_ready=1 -> one cycle after the 7th bit: data_out=4'hB, syndrome_out=0, err_corrected=0, out_valid pulses 1 cycle, frame_count=1, corr_count=0.
- Single error: send 7'h45 (7'h55 with bit 4 flipped) -> data_out=4'hB, syndrome_out=3'd5, err_corrected=1, corr_count=1. Repeat for each of the 7 bit positions of all 16 data words (encode as codes_ex_top does) -> always correct data, syndrome = position+1.
- Backpressure: out_ready=0, send 7'h00 then 7'h7F back-to-back with continuous bit_valid -> first word held (data_out=0). in_ready drops at the 7th bit of frame 2 and stays low until out_ready=1. Then data_out=4'hF follows; no frame lost; frame_count=2.
- Resync: send 3 bits of 7'h55, then frame_start with 7'h7F -> single output data_out=4'hF, frame_count=1. Bits with frame_start=0 in IDLE produce no output.
- Reset mid-operation: assert rst after 4 bits, and again with out_valid=1 and out_ready=0 -> next cycle out_valid=0, counters=0, in_ready=1. A following clean 7'h55 frame decodes to 4'hB.
- Saturation: COUNT_W=2, send 5 corrupted frames -> frame_count and corr_count stop at 3.
